router_pkt_reader: RTL and testbench

Read-side controller for one router output FIFO. It drains whole packets from the FIFO: a header byte {payload_len[5:0], addr[1:0]}, then payload_len payload bytes, then one parity byte. Each byte goes to the destination port over a valid/ready handshake, with start-of-packet and end-of-packet marks. The block also checks packet parity and aborts a packet through the FIFO soft reset when the destination stalls too long.

---
 rtl/router_pkt_reader.sv | 106 ++++++++++
 tb/tb_router_pkt_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: drains header/payload/parity packets from a router FIFO into a 2-entry skid buffer feeding a valid/ready port
module router_pkt_reader #(
  parameter int TIMEOUT = 30,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_en,
  output logic              fifo_soft_reset,
  input  logic              dst_ready,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_sop,
  output logic              dst_eop,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              timeout_err,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_HDR, STREAM, DRAIN} state_t;
  state_t state, state_nxt;
  logic [DATA_W+1:0] head, tail, in_entry;
  logic [1:0] occ;
  logic pend, pend_last;
  logic [6:0] remaining;
  logic [DATA_W-1:0] parity_acc;
  logic [CW-1:0] stall_cnt;
  logic pop, stall, timeout, perm;
  assign dst_valid = occ != 2'd0;
  assign {dst_sop, dst_eop, dst_data} = head;
  assign pop = dst_valid && dst_ready;
  assign stall = dst_valid && !dst_ready;
  assign timeout = stall && stall_cnt == LIM;
  assign fifo_soft_reset = timeout;
  assign timeout_err = timeout;
  assign pkt_done = pop && dst_eop;
  assign busy = state != IDLE || dst_valid;
  // counts the byte still in flight from the FIFO so a push always has room
  assign perm = ({1'b0, occ} - {2'b0, pop} + {2'b0, pend}) < 3'd2;
  assign in_entry = {state == WAIT_HDR, pend_last, fifo_data};
  always_comb begin
    state_nxt = state;
    fifo_read_en = 1'b0;
    case (state)
      IDLE: begin
        fifo_read_en = !fifo_empty;
        state_nxt = fifo_empty ? IDLE : WAIT_HDR;
      end
      WAIT_HDR: state_nxt = STREAM;
      STREAM: begin
        fifo_read_en = remaining != 7'd0 && perm && !fifo_empty;
        state_nxt = pend && pend_last ? DRAIN : STREAM;
      end
      DRAIN: begin
        fifo_read_en = pkt_done && !fifo_empty;
        state_nxt = !pkt_done ? DRAIN : fifo_empty ? IDLE : WAIT_HDR;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      fifo_read_en = 1'b0;
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset || timeout) begin
      head <= '0;
      tail <= '0;
      occ <= 2'd0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      remaining <= 7'd0;
      parity_acc <= '0;
      stall_cnt <= '0;
      parity_err <= 1'b0;
    end else begin
      pend <= fifo_read_en;
      pend_last <= fifo_read_en && state == STREAM && remaining == 7'd1;
      if (fifo_read_en && state == STREAM) remaining <= remaining - 7'd1;
      else if (pend && state == WAIT_HDR) remaining <= {1'b0, fifo_data[7:2]} + 7'd1;
      if (pend && state == WAIT_HDR) parity_acc <= fifo_data;
      else if (pend && !pend_last) parity_acc <= parity_acc ^ fifo_data;
      parity_err <= pend && pend_last && fifo_data != parity_acc;
      stall_cnt <= stall ? stall_cnt + 1'b1 : '0;
      if (pend && !pop) begin
        if (occ == 2'd0) head <= in_entry;
        else tail <= in_entry;
        occ <= occ + 2'd1;
      end else if (!pend && pop) begin
        head <= tail;
        occ <= occ - 2'd1;
      end else if (pend && pop) begin
        head <= occ == 2'd2 ? tail : in_entry;
        tail <= in_entry;
      end
    end
  end
endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader: randomized packet stimulus against a queue-based FIFO and expected byte stream
module tb_router_pkt_reader;
  localparam int TIMEOUT = 30;
  logic clock = 1'b0, reset, fifo_empty, fifo_read_en, fifo_soft_reset, dst_ready, dst_valid;
  logic dst_sop, dst_eop, pkt_done, parity_err, timeout_err, busy;
  logic [7:0] fifo_data, dst_data;
  int tests = 0, fails = 0;
  logic [7:0] src_q[$];
  logic [9:0] exp_q[$], obs_q[$];
  int pop_cyc[$];
  int n_done, n_perr, n_perr_wide, n_to, n_to_mis, n_rd_empty, stall_run, to_stall, cyc, max_occ, rd_total, pop_total;
  logic hold, rd_prev, prev_perr;

  router_pkt_reader #(.TIMEOUT(TIMEOUT), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_en(fifo_read_en), .fifo_soft_reset(fifo_soft_reset), .dst_ready(dst_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_sop(dst_sop), .dst_eop(dst_eop),
    .pkt_done(pkt_done), .parity_err(parity_err), .timeout_err(timeout_err), .busy(busy));

  always #5 clock = ~clock;

  task automatic clear_stats;
    obs_q.delete(); exp_q.delete(); pop_cyc.delete();
    n_done = 0; n_perr = 0; n_perr_wide = 0; n_to = 0; n_to_mis = 0; n_rd_empty = 0;
    stall_run = 0; to_stall = 0; max_occ = 0; rd_total = 0; pop_total = 0;
    rd_prev = 1'b0; prev_perr = 1'b0;
  endtask

  task automatic build_pkt(input int len, input int addr, input bit bad);
    logic [7:0] h, b, p;
    h = {len[5:0], addr[1:0]};
    src_q.push_back(h); exp_q.push_back({2'b10, h});
    p = h;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      p ^= b;
      src_q.push_back(b); exp_q.push_back({2'b00, b});
    end
    p ^= {7'd0, bad};
    src_q.push_back(p); exp_q.push_back({2'b01, p});
  endtask

  // one clock: drive at negedge, observe, then play the FIFO's one-cycle read latency
  task automatic tick;
    int occ;
    bit flushed;
    fifo_empty = hold || src_q.size() == 0;
    #1;
    cyc++;
    occ = rd_total - int'(rd_prev) - pop_total;
    if (occ > max_occ) max_occ = occ;
    if (fifo_read_en && fifo_empty) n_rd_empty++;
    if (fifo_read_en) rd_total++;
    rd_prev = fifo_read_en;
    if (dst_valid && dst_ready) begin
      obs_q.push_back({dst_sop, dst_eop, dst_data});
      pop_cyc.push_back(cyc);
      pop_total++;
    end
    stall_run = (dst_valid && !dst_ready) ? stall_run + 1 : 0;
    if (pkt_done) n_done++;
    if (parity_err) n_perr++;
    if (parity_err && prev_perr) n_perr_wide++;
    prev_perr = parity_err;
    if (fifo_soft_reset !== timeout_err) n_to_mis++;
    if (fifo_soft_reset) begin n_to++; to_stall = stall_run; end
    flushed = fifo_soft_reset;
    @(posedge clock); #1;
    if (flushed) begin
      src_q.delete(); rd_total = 0; pop_total = 0; rd_prev = 1'b0;
    end else if (rd_prev && src_q.size() > 0) fifo_data = src_q.pop_front();
    @(negedge clock);
  endtask

  task automatic run(input int mode, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      dst_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(i & 1) : ($urandom_range(3) != 0);
      tick;
      if (src_q.size() == 0 && obs_q.size() >= exp_q.size() && !busy) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; hold = 1'b1; fifo_empty = 1'b1; dst_ready = 1'b0; fifo_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({fifo_read_en, fifo_soft_reset, dst_valid, dst_data, dst_sop, dst_eop, pkt_done, parity_err, timeout_err} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %b want 0", {fifo_read_en, fifo_soft_reset, dst_valid, dst_data, dst_sop, dst_eop, pkt_done, parity_err, timeout_err});
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b0; hold = 1'b0;
    clear_stats;
  endtask

  task automatic test_basic;
    bit ok;
    clear_stats;
    build_pkt(14, 1, 1'b0);
    tests++;
    if (exp_q[0] !== {2'b10, 8'h39}) begin fails++; $display("FAIL basic_hdr_model: got %h want 239", exp_q[0]); end
    run(0, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_bound: got timeout want completion"); end
    tests++;
    if (obs_q.size() != 16) begin fails++; $display("FAIL basic_count: got %0d want 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (pop_cyc.size() == 16 && pop_cyc[15] - pop_cyc[1] != 14) begin
      fails++; $display("FAIL basic_b2b: got span %0d want 14", pop_cyc[15] - pop_cyc[1]);
    end
    tests++;
    if (n_done != 1 || n_perr != 0) begin fails++; $display("FAIL basic_flags: got done=%0d perr=%0d want 1 0", n_done, n_perr); end
  endtask

  task automatic test_bad_parity;
    bit ok;
    clear_stats;
    build_pkt(14, 1, 1'b1);
    run(0, 200, ok);
    tests++;
    if (!ok || obs_q.size() != 16) begin fails++; $display("FAIL badpar_count: got %0d ok=%0d want 16", obs_q.size(), ok); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL badpar_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (n_perr != 1 || n_perr_wide != 0 || n_done != 1) begin
      fails++; $display("FAIL badpar_flags: got perr=%0d wide=%0d done=%0d want 1 0 1", n_perr, n_perr_wide, n_done);
    end
  endtask

  task automatic test_zero_len;
    bit ok;
    clear_stats;
    build_pkt(0, 2, 1'b0);
    run(0, 50, ok);
    tests++;
    if (!ok || obs_q.size() != 2) begin fails++; $display("FAIL zero_count: got %0d ok=%0d want 2", obs_q.size(), ok); end
    tests++;
    if (obs_q.size() == 2 && (obs_q[0] !== 10'h202 || obs_q[1] !== 10'h102)) begin
      fails++; $display("FAIL zero_bytes: got %h %h want 202 102", obs_q[0], obs_q[1]);
    end
    tests++;
    if (n_perr != 0 || n_done != 1) begin fails++; $display("FAIL zero_flags: got perr=%0d done=%0d want 0 1", n_perr, n_done); end
  endtask

  task automatic test_toggle;
    bit ok;
    clear_stats;
    build_pkt(14, 0, 1'b0);
    run(1, 300, ok);
    tests++;
    if (!ok || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL toggle_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL toggle_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (n_rd_empty != 0 || max_occ > 2 || n_done != 1) begin
      fails++; $display("FAIL toggle_rules: got rd_empty=%0d max_occ=%0d done=%0d want 0 <=2 1", n_rd_empty, max_occ, n_done);
    end
  endtask

  task automatic test_timeout;
    clear_stats;
    build_pkt(14, 1, 1'b0);
    dst_ready = 1'b1;
    for (int i = 0; i < 200 && n_to == 0; i++) begin
      tick;
      if (obs_q.size() >= 1) dst_ready = 1'b0;
    end
    tests++;
    if (n_to != 1 || to_stall != TIMEOUT) begin fails++; $display("FAIL timeout_cycle: got n=%0d stall=%0d want 1 %0d", n_to, to_stall, TIMEOUT); end
    tests++;
    if (n_to_mis != 0) begin fails++; $display("FAIL timeout_pair: got %0d mismatches want 0", n_to_mis); end
    tests++;
    if (dst_valid !== 1'b0 || busy !== 1'b0 || fifo_soft_reset !== 1'b0) begin
      fails++; $display("FAIL timeout_after: got valid=%b busy=%b sr=%b want 0 0 0", dst_valid, busy, fifo_soft_reset);
    end
    tests++;
    if (n_done != 0) begin fails++; $display("FAIL timeout_done: got %0d want 0", n_done); end
    dst_ready = 1'b1;
  endtask

  task automatic test_fifo_empty;
    bit ok;
    clear_stats;
    build_pkt(14, 1, 1'b0);
    build_pkt(5, 3, 1'b0);
    dst_ready = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < 5; i++) tick;
    hold = 1'b1;
    repeat (10) tick;
    hold = 1'b0;
    run(0, 300, ok);
    tests++;
    if (!ok || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL empty_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL empty_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (n_to != 0 || n_done != 2 || n_rd_empty != 0) begin
      fails++; $display("FAIL empty_flags: got to=%0d done=%0d rd_empty=%0d want 0 2 0", n_to, n_done, n_rd_empty);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    clear_stats;
    build_pkt(14, 1, 1'b0);
    dst_ready = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < 5; i++) tick;
    reset = 1'b1; hold = 1'b1; fifo_empty = 1'b1;
    src_q.delete();
    @(posedge clock); #1;
    tests++;
    if ({fifo_read_en, fifo_soft_reset, dst_valid, dst_data, dst_sop, dst_eop, pkt_done, parity_err, timeout_err, busy} !== '0) begin
      fails++; $display("FAIL midreset_outputs: got %b want 0", {fifo_read_en, fifo_soft_reset, dst_valid, dst_data, dst_sop, dst_eop, pkt_done, parity_err, timeout_err, busy});
    end
    @(negedge clock);
    reset = 1'b0; hold = 1'b0;
    clear_stats;
    build_pkt(14, 2, 1'b0);
    run(0, 200, ok);
    tests++;
    if (!ok || obs_q.size() != 16) begin fails++; $display("FAIL midreset_count: got %0d want 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL midreset_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (n_done != 1) begin fails++; $display("FAIL midreset_done: got %0d want 1", n_done); end
  endtask

  task automatic test_random;
    bit ok, bad;
    int nbad;
    clear_stats;
    nbad = 0;
    for (int p = 0; p < 6; p++) begin
      bad = $urandom_range(1);
      nbad += int'(bad);
      build_pkt(int'($urandom_range(63)), int'($urandom_range(3)), bad);
    end
    run(2, 3000, ok);
    tests++;
    if (!ok || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (n_done != 6 || n_perr != nbad || n_perr_wide != 0 || n_to != 0) begin
      fails++; $display("FAIL rand_flags: got done=%0d perr=%0d wide=%0d to=%0d want 6 %0d 0 0", n_done, n_perr, n_perr_wide, n_to, nbad);
    end
    tests++;
    if (n_rd_empty != 0 || max_occ > 2) begin fails++; $display("FAIL rand_rules: got rd_empty=%0d max_occ=%0d want 0 <=2", n_rd_empty, max_occ); end
  endtask

  initial begin
    cyc = 0;
    clear_stats;
    test_reset;
    test_basic;
    test_bad_parity;
    test_zero_len;
    test_toggle;
    test_timeout;
    test_fifo_empty;
    test_mid_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
